// File: rtl/dram_sram_responder_pkg.sv
// Shared types and constants for the DRAM-request to async-SRAM responder.
package dram_sram_responder_pkg;

  // Access sequencing states. The half-access sub-module walks Idle/Setup/Strobe/Recover;
  // the top uses Idle, Setup (half accesses in flight) and Ack.
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StRecover,
    StAck
  } state_e;

  // Half-word select: bit 0 of the SRAM half-word address.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam int unsigned SRAM_DW = 16;

endpackage

// File: rtl/dram_sram_responder_if.sv
// MCU-side word request bus: one request pulse in, one ack pulse out.
interface dram_sram_responder_if #(
  parameter int unsigned ADDR_BITS = 16
) ();

  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_read_en;
  logic                 mem_write_en;
  logic [3:0]           mem_byte_enable;
  logic [31:0]          mem_write_data;
  logic                 mem_ack;
  logic [31:0]          mem_read_data;

  modport master (
    output mem_addr, mem_read_en, mem_write_en, mem_byte_enable, mem_write_data,
    input  mem_ack, mem_read_data
  );

  modport slave (
    input  mem_addr, mem_read_en, mem_write_en, mem_byte_enable, mem_write_data,
    output mem_ack, mem_read_data
  );

endinterface

// File: rtl/dram_sram_responder_sram_half_access.sv
// One SETUP / STROBE / RECOVER access to the 16-bit async SRAM.
// Address, data and lanes are held stable by the caller for the whole access.
module dram_sram_responder_sram_half_access
  import dram_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sync_reset,
  input  logic               go,
  input  logic               is_write,
  input  logic [ADDR_BITS:0] addr,
  input  logic [SRAM_DW-1:0] data,
  input  logic [1:0]         lanes,
  output logic [ADDR_BITS:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n,
  output logic               done,
  output logic [SRAM_DW-1:0] rdata
);

  localparam logic [3:0] StrobeLast = 4'(WAIT_CYCLES - 1);

  state_e             st_q, st_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SRAM_DW-1:0] rdata_q, rdata_d;

  assign sram_addr   = addr;
  assign sram_dq_out = data;
  assign rdata       = rdata_q;

  // Phase register, strobe counter and captured read half.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else if (sync_reset) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Phase sequencing and pin decode; strobes are pure functions of the phase so reset
  // drops them in the same cycle.
  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    done       = 1'b0;
    sram_ce_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_dq_oe = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (go) st_d = StSetup;
      end
      StSetup: begin
        sram_ce_n  = 1'b0;
        sram_ub_n  = is_write ? !lanes[1] : 1'b0;
        sram_lb_n  = is_write ? !lanes[0] : 1'b0;
        sram_dq_oe = is_write;
        cnt_d      = StrobeLast;
        st_d       = StStrobe;
      end
      StStrobe: begin
        sram_ce_n  = 1'b0;
        sram_ub_n  = is_write ? !lanes[1] : 1'b0;
        sram_lb_n  = is_write ? !lanes[0] : 1'b0;
        sram_dq_oe = is_write;
        sram_we_n  = !is_write;
        sram_oe_n  = is_write;
        if (cnt_q == 4'd0) begin
          st_d = StRecover;
          if (!is_write) rdata_d = sram_dq_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRecover: begin
        // Keep driving write data through the hold window.
        sram_dq_oe = is_write;
        done       = 1'b1;
        st_d       = go ? StSetup : StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

endmodule

// File: rtl/dram_sram_responder.sv
// Executes MCU word read/write requests as one or two half-word async-SRAM accesses.
module dram_sram_responder
  import dram_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  dram_sram_responder_if.slave mem,
  output logic [ADDR_BITS:0]   sram_addr,
  output logic [SRAM_DW-1:0]   sram_dq_out,
  output logic                 sram_dq_oe,
  input  logic [SRAM_DW-1:0]   sram_dq_in,
  output logic                 sram_ce_n,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n
);

  state_e               st_q, st_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic                 wr_q, wr_d;
  logic                 half_q, half_d;
  logic [SRAM_DW-1:0]   rd_lo_q, rd_lo_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 go, ack, acc_done;
  logic [SRAM_DW-1:0]   acc_rdata;

  assign mem.mem_ack       = ack;
  assign mem.mem_read_data = rdata_q;

  dram_sram_responder_sram_half_access #(
    .ADDR_BITS  (ADDR_BITS),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_half (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset),
    .go         (go),
    .is_write   (wr_q),
    .addr       ({addr_q, half_q}),
    .data       (half_q ? wdata_q[31:16] : wdata_q[15:0]),
    .lanes      (half_q ? be_q[3:2] : be_q[1:0]),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_ce_n  (sram_ce_n),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n),
    .done       (acc_done),
    .rdata      (acc_rdata)
  );

  // Request latch, half tracking and read-word assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      half_q  <= HALF_LO;
      rd_lo_q <= '0;
      rdata_q <= '0;
    end else if (sync_reset) begin
      st_q    <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      half_q  <= HALF_LO;
      rd_lo_q <= '0;
      rdata_q <= '0;
    end else begin
      st_q    <= st_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      half_q  <= half_d;
      rd_lo_q <= rd_lo_d;
      rdata_q <= rdata_d;
    end
  end

  // Accept in Idle only, pick halves, chain them, then a one-cycle ack.
  always_comb begin
    st_d    = st_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    half_d  = half_q;
    rd_lo_d = rd_lo_q;
    rdata_d = rdata_q;
    go      = 1'b0;
    ack     = 1'b0;
    unique case (st_q)
      StIdle: begin
        // Write wins when both enables are high.
        if (mem.mem_write_en) begin
          addr_d  = mem.mem_addr;
          wdata_d = mem.mem_write_data;
          be_d    = mem.mem_byte_enable;
          wr_d    = 1'b1;
          if (mem.mem_byte_enable == 4'b0000) begin
            st_d = StAck;
          end else begin
            half_d = (mem.mem_byte_enable[1:0] != 2'b00) ? HALF_LO : HALF_HI;
            go     = 1'b1;
            st_d   = StSetup;
          end
        end else if (mem.mem_read_en) begin
          addr_d = mem.mem_addr;
          wr_d   = 1'b0;
          half_d = HALF_LO;
          go     = 1'b1;
          st_d   = StSetup;
        end
      end
      StSetup: begin
        // Here StSetup covers the whole run of half accesses; the sub-module owns the phase.
        if (acc_done) begin
          if (half_q == HALF_LO) rd_lo_d = acc_rdata;
          if (half_q == HALF_LO && (!wr_q || be_q[3:2] != 2'b00)) begin
            go     = 1'b1;
            half_d = HALF_HI;
          end else begin
            st_d = StAck;
            if (!wr_q) rdata_d = {acc_rdata, rd_lo_q};
          end
        end
      end
      StAck: begin
        ack  = 1'b1;
        st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dram_sram_responder.sv
// Randomised scoreboard bench: word-level reference memory vs. DUT driving a modelled SRAM.
module tb_dram_sram_responder;

  localparam int unsigned AB = 16;
  localparam int WC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, sync_reset;
  logic [AB:0]   sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;

  dram_sram_responder_if #(.ADDR_BITS(AB)) mem ();

  dram_sram_responder #(
    .ADDR_BITS  (AB),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset),
    .mem        (mem),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_ce_n  (sram_ce_n),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- board SRAM model ----------------
  typedef struct {
    logic [AB:0] a;
    logic [15:0] d;
    logic [1:0]  lanes_n;
    int          lows;
  } wlog_t;

  logic [15:0] sram [0:(1<<(AB+1))-1];
  wlog_t       wlog[$];
  wlog_t       cur = '{a: '0, d: '0, lanes_n: 2'b11, lows: 0};
  int          acc_cnt = 0;
  logic        ce_prev = 1'b1;

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr] : 16'hdead;

  always @(negedge clk) begin
    ce_prev <= sram_ce_n;
    if (!sram_ce_n && ce_prev) acc_cnt <= acc_cnt + 1;
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) sram[sram_addr][7:0]  <= sram_dq_oe ? sram_dq_out[7:0]  : 8'hxx;
      if (!sram_ub_n) sram[sram_addr][15:8] <= sram_dq_oe ? sram_dq_out[15:8] : 8'hxx;
      cur.a       <= sram_addr;
      cur.d       <= sram_dq_out;
      cur.lanes_n <= {sram_ub_n, sram_lb_n};
      cur.lows    <= cur.lows + 1;
    end else if (cur.lows > 0) begin
      wlog.push_back(cur);
      cur.lows <= 0;
    end
  end

  // ---------------- word-level reference model ----------------
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd = '0;

  function automatic logic [31:0] ref_rd(input logic [AB-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  task automatic ref_wr(input logic [AB-1:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    w = ref_rd(a);
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[int'(a)] = w;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    bit          is_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  int   acc0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && mem.mem_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", {31'h0, mem.mem_ack}, 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          chk(e.is_rd ? "read_data" : "read_data_held", mem.mem_read_data, e.rd);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit rd, input bit wr, input logic [AB-1:0] a, input logic [3:0] be,
                       input logic [31:0] d, output int lat, output int halves, output int c0);
    exp_t e;
    @(posedge clk);
    #1;
    mem.mem_addr        = a;
    mem.mem_read_en     = rd;
    mem.mem_write_en    = wr;
    mem.mem_byte_enable = be;
    mem.mem_write_data  = d;
    c0 = cyc;
    halves = 0;
    if (wr) begin
      if (be[1:0] != 2'b00) halves++;
      if (be[3:2] != 2'b00) halves++;
      ref_wr(a, be, d);
      e.is_rd = 1'b0;
      e.rd    = last_rd;
    end else begin
      halves  = 2;
      e.is_rd = 1'b1;
      e.rd    = ref_rd(a);
      last_rd = e.rd;
    end
    lat   = 1 + halves * (WC + 2);
    e.cyc = c0 + lat;
    q.push_back(e);
    acc0 = acc_cnt;
    @(posedge clk);
    #1;
    mem.mem_read_en     = 1'b0;
    mem.mem_write_en    = 1'b0;
    // Scramble the bus so anything not latched at acceptance shows up.
    mem.mem_addr        = AB'($urandom);
    mem.mem_write_data  = $urandom;
    mem.mem_byte_enable = 4'($urandom);
  endtask

  task automatic wait_ack(input string nm);
    bit seen = 1'b0;
    int n = 0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      if (mem.mem_ack) seen = 1'b1;
      n++;
    end
    chk({nm, "_ack_seen"}, {31'h0, seen}, 32'h1);
    if (!seen) q.delete();
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [AB-1:0] a, input logic [3:0] be,
                        input logic [31:0] d, input bit extra, input string nm);
    int lat, halves, c0;
    issue(rd, wr, a, be, d, lat, halves, c0);
    if (extra && lat > 4) begin
      while (cyc < c0 + 3) begin
        @(posedge clk);
        #1;
      end
      mem.mem_read_en  = 1'b1;
      mem.mem_write_en = 1'($urandom);
      @(posedge clk);
      #1;
      mem.mem_read_en  = 1'b0;
      mem.mem_write_en = 1'b0;
    end
    wait_ack(nm);
    chk({nm, "_accesses"}, 32'(acc_cnt - acc0), 32'(halves));
  endtask

  task automatic chk_idle_pins(input string nm);
    chk({nm, "_strobes"}, {27'h0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n},
        32'h1f);
    chk({nm, "_dq_oe"}, {31'h0, sram_dq_oe}, 32'h0);
    chk({nm, "_ack"}, {31'h0, mem.mem_ack}, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, halves, c0;
    logic [AB-1:0] rnd_addr;
    int op;
    for (int i = 0; i < (1 << (AB + 1)); i++) sram[i] = 16'h0000;
    reset_n             = 1'b0;
    sync_reset          = 1'b0;
    mem.mem_addr        = '0;
    mem.mem_read_en     = 1'b0;
    mem.mem_write_en    = 1'b0;
    mem.mem_byte_enable = '0;
    mem.mem_write_data  = '0;
    @(posedge clk);
    #1;
    chk_idle_pins("reset");
    chk("reset_read_data", mem.mem_read_data, 32'h0);
    chk("reset_sram_addr", 32'(sram_addr), 32'h0);
    chk("reset_dq_out", 32'(sram_dq_out), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Full-word write: two halves, low half first.
    wlog.delete();
    do_req(1'b0, 1'b1, 16'h0040, 4'hf, 32'h12345678, 1'b0, "t1_write");
    chk("t1_log_n", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("t1_h0_addr", 32'(wlog[0].a), 32'h80);
      chk("t1_h0_data", 32'(wlog[0].d), 32'h5678);
      chk("t1_h0_we_cycles", 32'(wlog[0].lows), 32'(WC));
      chk("t1_h0_lanes", 32'(wlog[0].lanes_n), 32'h0);
      chk("t1_h1_addr", 32'(wlog[1].a), 32'h81);
      chk("t1_h1_data", 32'(wlog[1].d), 32'h1234);
      chk("t1_h1_we_cycles", 32'(wlog[1].lows), 32'(WC));
    end

    do_req(1'b1, 1'b0, 16'h0040, 4'h0, 32'h0, 1'b0, "t2_read");

    // Single-byte write lands in the upper half only.
    wlog.delete();
    do_req(1'b0, 1'b1, 16'h0040, 4'b0100, 32'h00AB0000, 1'b0, "t3_write");
    chk("t3_log_n", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) begin
      chk("t3_addr", 32'(wlog[0].a), 32'h81);
      chk("t3_data", 32'(wlog[0].d), 32'h00AB);
      chk("t3_lanes_ub_lb", 32'(wlog[0].lanes_n), 32'h2);
    end
    do_req(1'b1, 1'b0, 16'h0040, 4'h0, 32'h0, 1'b0, "t3_read");

    do_req(1'b0, 1'b1, 16'h0055, 4'b0000, 32'hFFFFFFFF, 1'b0, "t4_be0");

    do_req(1'b1, 1'b0, 16'h0040, 4'h0, 32'h0, 1'b1, "t5_read_pulse");
    do_req(1'b1, 1'b1, 16'h0041, 4'hf, 32'hCAFEF00D, 1'b0, "t5_both");
    do_req(1'b1, 1'b0, 16'h0041, 4'h0, 32'h0, 1'b0, "t5_readback");

    // Asynchronous abort: rewrite the current value so a partial write is harmless.
    issue(1'b0, 1'b1, 16'h0040, 4'hf, ref_rd(16'h0040), lat, halves, c0);
    while (cyc < c0 + 3) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    chk_idle_pins("t6_async");
    q.delete();
    last_rd = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("t6_async_read_data", mem.mem_read_data, 32'h0);
    repeat (10) @(posedge clk);
    do_req(1'b1, 1'b0, 16'h0040, 4'h0, 32'h0, 1'b0, "t6_async_read");

    issue(1'b0, 1'b1, 16'h0040, 4'hf, ref_rd(16'h0040), lat, halves, c0);
    while (cyc < c0 + 3) begin
      @(posedge clk);
      #1;
    end
    sync_reset = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_pins("t6_sync");
    q.delete();
    last_rd = '0;
    sync_reset = 1'b0;
    chk("t6_sync_read_data", mem.mem_read_data, 32'h0);
    repeat (10) @(posedge clk);
    do_req(1'b1, 1'b0, 16'h0040, 4'h0, 32'h0, 1'b0, "t6_sync_read");

    // Random mix over a small address pool plus the address extremes.
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 9));
      case ($urandom_range(0, 9))
        8:       rnd_addr = 16'h0000;
        9:       rnd_addr = 16'hFFFF;
        default: rnd_addr = 16'h0100 + AB'($urandom_range(0, 7));
      endcase
      if (op <= 3)
        do_req(1'b1, 1'b0, rnd_addr, 4'h0, 32'h0, ($urandom_range(0, 3) == 0), "rnd_read");
      else if (op <= 7)
        do_req(1'b0, 1'b1, rnd_addr, 4'($urandom), $urandom, ($urandom_range(0, 3) == 0),
               "rnd_write");
      else if (op == 8)
        do_req(1'b0, 1'b1, rnd_addr, 4'h0, $urandom, 1'b0, "rnd_be0");
      else
        do_req(1'b1, 1'b1, rnd_addr, 4'($urandom), $urandom, 1'b0, "rnd_both");
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_sram_responder.md
Name: dram_sram_responder

Overview:
- Target side of the MCU's external DRAM request interface: accepts word read/write requests from the MCU, executes them on a 16-bit asynchronous external SRAM, and returns a single-cycle ack.
- Sits at chip top, between the MCU's dram_* ports and the board SRAM pins.
- Each 32-bit word is handled as two half-word SRAM accesses, or fewer for byte-masked writes.

Parameters:
- ADDR_BITS, 16: word-address width; equals MCU MEM_ADDR_BITS.
- WAIT_CYCLES, 2: strobe-low cycles per SRAM access; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous reset; same effect as reset_n, applied on clock edge
- mem_addr  in  ADDR_BITS  word address
- mem_read_en  in  1  read request pulse
- mem_write_en  in  1  write request pulse
- mem_byte_enable  in  4  write byte lanes; bit0 = bits[7:0]
- mem_write_data  in  32  write word
- mem_ack  out  1  single-cycle completion pulse
- mem_read_data  out  32  read word
- sram_addr  out  ADDR_BITS+1  half-word address = {mem_addr, half}
- sram_dq_out  out  16  data driven to SRAM
- sram_dq_oe  out  1  tristate enable for sram_dq_out
- sram_dq_in  in  16  data from SRAM
- sram_ce_n, sram_we_n, sram_oe_n  out  1 each  active-low strobes
- sram_ub_n, sram_lb_n  out  1 each  active-low byte lanes (upper/lower)

Behaviour:
- Reset values: mem_ack=0, mem_read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, all sram_*_n=1. State goes to IDLE.
- Reset mid-operation: the asynchronous reset forces strobes high in the same cycle. The operation is aborted and no ack is issued.
- Request acceptance:
  - A request is sampled only in IDLE. Cycle 0 is the cycle in which read_en or write_en is high.
  - Address, data and byte enables are latched at cycle 0.
  - Requests arriving while not in IDLE are ignored; they are neither queued nor acked.
  - If read_en and write_en are both high, the write is performed and the read is dropped.
- Half sequence:
  - Reads always access half0 (addr LSB=0, bits[15:0]) and then half1 (bits[31:16]).
  - Writes access half0 only if be[1:0]≠0, and half1 only if be[3:2]≠0.
  - For writes, lb_n/ub_n follow the corresponding be bits. For reads, both are low.
- Per-half access, three phases:
  - SETUP, 1 cycle: addr valid, ce_n=0, oe_n=1, we_n=1. For writes, dq_oe=1.
  - STROBE, WAIT_CYCLES cycles: we_n=0 (write) or oe_n=0 (read). Read data is captured from sram_dq_in on the last STROBE cycle.
  - RECOVER, 1 cycle: strobes high. For writes, dq stays driven; dq_oe drops at the end of RECOVER.
  - Back-to-back halves go straight from RECOVER to the next SETUP.
- FSM states: IDLE → SETUP → STROBE (counter) → RECOVER → SETUP (next half) or ACK → IDLE.
  - A write with be=0000 goes IDLE → ACK directly, with no SRAM activity.
- Latency with H halves: ack at cycle 1 + H·(WAIT_CYCLES+2).
  - With default WAIT_CYCLES=2: 2 halves = cycle 9, 1 half = cycle 5, 0 halves = cycle 1.
- mem_ack is high for exactly one cycle.
- mem_read_data is updated on the read ack cycle and holds until the next read ack. Writes do not change it.
- The earliest next request is accepted in the cycle after ack.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, SETUP, STROBE, RECOVER, ACK).
  - Half-select constants HALF_LO=0 and HALF_HI=1.
  - SRAM data width 16.
- Sub-module sram_half_access:
  - Sequences one SETUP/STROBE/RECOVER access.
  - Inputs: go, is_write, addr, data, lane mask.
  - Outputs: pins, done, rdata.
  - The top FSM handles request latch, half selection and ack.

Test Plan:
1. Write addr 0x0040, data 0x12345678, be=1111:
   - SRAM write 0x5678 at 0x0080, then 0x1234 at 0x0081.
   - we_n low for 2 cycles per half.
   - mem_ack at cycle 9.
2. Read addr 0x0040 after test 1:
   - Two reads at 0x0080 and 0x0081.
   - mem_read_data=0x12345678 on the ack cycle (cycle 9).
   - Value held through a subsequent write.
3. Write addr 0x0040, data 0x00AB0000, be=0100:
   - Single access at 0x0081 with ub_n=1, lb_n=0, dq=0x00AB.
   - Ack at cycle 5.
   - Follow-up read returns 0x12AB5678.
4. Write with be=0000:
   - Ack at cycle 1.
   - ce_n stays 1 throughout.
5. Second read_en pulse at cycle 3 of an active read:
   - Ignored; exactly one ack (cycle 9).
   - Next request is served after IDLE.
   - read_en and write_en high together performs the write only.
6. reset_n low at cycle 3 of a write:
   - ce_n/we_n=1 and dq_oe=0 immediately.
   - No ack.
   - After release, a read of the same address completes normally at cycle 9.
   - Repeat with sync_reset: identical result on the next edge.
